// File: rtl/fft_reorder_pkg.sv
// Shared FFT helpers: constant log2/bit-reverse functions and the reorder read FSM encoding.

package fft_reorder_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRead = 1'b1
   } rd_state_e;

   // Ceiling log2; exact for the power-of-two sizes used here.
   function automatic int unsigned log2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Reverse the low 'bits' bits of v.
   function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = v;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < bits) begin
            r = (r << 1) | (x & 32'd1);
            x = x >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_if.sv
// Sample stream bundle for the FFT reorder buffer: bit-reversed samples in, natural order out.

interface fft_reorder_if #(
   parameter int unsigned WIDTH = 16
);

   logic             idata_en;
   logic [WIDTH-1:0] idata_r;
   logic [WIDTH-1:0] idata_i;
   logic             odata_en;
   logic [WIDTH-1:0] odata_r;
   logic [WIDTH-1:0] odata_i;

   modport master (
      output idata_en,
      output idata_r,
      output idata_i,
      input  odata_en,
      input  odata_r,
      input  odata_i
   );

   modport slave (
      input  idata_en,
      input  idata_r,
      input  idata_i,
      output odata_en,
      output odata_r,
      output odata_i
   );

endinterface

// File: rtl/reorder_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port (1-cycle latency).

module reorder_ram #(
   parameter int unsigned Depth     = 128,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 7
) (
   input  logic                 clock,
   input  logic                 we,
   input  logic [AddrWidth-1:0] waddr,
   input  logic [DataWidth-1:0] wdata,
   input  logic                 re,
   input  logic [AddrWidth-1:0] raddr,
   output logic [DataWidth-1:0] rdata
);

   logic [DataWidth-1:0] mem [Depth];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed FFT frames, reads them back in natural order.

module fft_reorder
   import fft_reorder_pkg::*;
#(
   parameter int unsigned N     = 64,
   parameter int unsigned WIDTH = 16
) (
   input logic          clock,
   input logic          reset,
   fft_reorder_if.slave bus
);

   localparam int unsigned AW = log2(N);
   localparam logic [AW-1:0] LastAddr = AW'(N - 1);

   logic [AW-1:0]      wcnt_q, wcnt_d;
   logic               wbank_q, wbank_d;
   logic [1:0]         full_q, full_d;
   logic               rbank_q, rbank_d;
   logic [AW-1:0]      raddr_q, raddr_d;
   rd_state_e          state_q, state_d;
   logic               rd_valid_q;
   logic               wr_done, rd_done;
   logic               ram_we, ram_re;
   logic [AW:0]        ram_waddr, ram_raddr;
   logic [2*WIDTH-1:0] ram_rdata;

   // Write side: position counter, bank select, frame completion.
   always_comb begin
      wcnt_d    = '0;
      wbank_d   = wbank_q;
      wr_done   = 1'b0;
      ram_we    = bus.idata_en;
      ram_waddr = {wbank_q, AW'(bitrev(32'(wcnt_q), AW))};
      if (bus.idata_en) begin
         if (wcnt_q == LastAddr) begin
            wr_done = 1'b1;
            wbank_d = ~wbank_q;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
         end
      end
   end

   // Read FSM. Leaving IDLE issues address 0 right away so the first word reaches
   // the output register N+1 edges after the first input sample.
   always_comb begin
      state_d   = state_q;
      raddr_d   = raddr_q;
      rbank_d   = rbank_q;
      rd_done   = 1'b0;
      ram_re    = 1'b0;
      ram_raddr = {rbank_q, raddr_q};
      case (state_q)
         StIdle: begin
            if (full_q[rbank_q]) begin
               ram_re    = 1'b1;
               ram_raddr = {rbank_q, {AW{1'b0}}};
               raddr_d   = AW'(1);
               state_d   = StRead;
            end
         end
         StRead: begin
            ram_re = 1'b1;
            if (raddr_q == LastAddr) begin
               rd_done = 1'b1;
               rbank_d = ~rbank_q;
               raddr_d = '0;
               // The other bank may be completing on this very edge.
               if (!(full_q[~rbank_q] || (wr_done && (wbank_q == ~rbank_q)))) begin
                  state_d = StIdle;
               end
            end else begin
               raddr_d = raddr_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Completion is applied after the clear so a new frame's flag always wins.
   always_comb begin
      full_d = full_q;
      if (rd_done) full_d[rbank_q] = 1'b0;
      if (wr_done) full_d[wbank_q] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wcnt_q     <= '0;
         wbank_q    <= 1'b0;
         full_q     <= '0;
         rbank_q    <= 1'b0;
         raddr_q    <= '0;
         state_q    <= StIdle;
         rd_valid_q <= 1'b0;
      end else begin
         wcnt_q     <= wcnt_d;
         wbank_q    <= wbank_d;
         full_q     <= full_d;
         rbank_q    <= rbank_d;
         raddr_q    <= raddr_d;
         state_q    <= state_d;
         rd_valid_q <= ram_re;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.odata_en <= 1'b0;
         bus.odata_r  <= '0;
         bus.odata_i  <= '0;
      end else begin
         bus.odata_en <= rd_valid_q;
         if (rd_valid_q) begin
            bus.odata_r <= ram_rdata[2*WIDTH-1:WIDTH];
            bus.odata_i <= ram_rdata[WIDTH-1:0];
         end
      end
   end

   reorder_ram #(
      .Depth    (2 * N),
      .DataWidth(2 * WIDTH),
      .AddrWidth(AW + 1)
   ) u_ram (
      .clock(clock),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata({bus.idata_r, bus.idata_i}),
      .re   (ram_re),
      .raddr(ram_raddr),
      .rdata(ram_rdata)
   );

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder: N=64 and N=4 instances, expected stream timed per element.

module tb_fft_reorder;

   typedef struct {
      int unsigned cyc;
      logic [15:0] r;
      logic [15:0] i;
   } exp_t;

   logic        clock;
   logic        reset;
   int unsigned cyc;
   int          n_checks;
   int          n_fail;
   int          seen64;
   exp_t        q64[$];
   exp_t        q4[$];

   fft_reorder_if #(.WIDTH(16)) bus64 ();
   fft_reorder_if #(.WIDTH(16)) bus4 ();

   fft_reorder #(.N(64), .WIDTH(16)) dut64 (
      .clock(clock),
      .reset(reset),
      .bus  (bus64)
   );

   fft_reorder #(.N(4), .WIDTH(16)) dut4 (
      .clock(clock),
      .reset(reset),
      .bus  (bus4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic int brev(input int p, input int lg);
      int r = 0;
      for (int b = 0; b < lg; b++) begin
         if (((p >> b) & 1) == 1) r += 1 << (lg - 1 - b);
      end
      return r;
   endfunction

   task automatic drive(input int which, input logic en, input logic [15:0] r,
                        input logic [15:0] i);
      if (which == 4) begin
         bus4.idata_en = en;
         bus4.idata_r  = r;
         bus4.idata_i  = i;
      end else begin
         bus64.idata_en = en;
         bus64.idata_r  = r;
         bus64.idata_i  = i;
      end
   endtask

   task automatic idle(input int which, input int k);
      drive(which, 1'b0, 16'h0, 16'h0);
      repeat (k) begin
         @(posedge clock);
         #1;
      end
   endtask

   // mode 0: random data; mode 1: r = offset+element, i = -(offset+element).
   // Called #1 after an edge; position 0 is captured on the following edge.
   task automatic send(input int which, input int len, input int mode, input int offset);
      int          lg;
      int          e;
      int unsigned t0;
      logic [15:0] r, i;
      logic [15:0] er[64];
      logic [15:0] ei[64];
      exp_t        x;
      lg = (which == 4) ? 2 : 6;
      t0 = cyc + 1;
      for (int p = 0; p < len; p++) begin
         e = brev(p, lg);
         if (mode == 1) begin
            r = 16'(offset + e);
            i = 16'(-(offset + e));
         end else begin
            r = 16'($urandom);
            i = 16'($urandom);
         end
         er[e] = r;
         ei[e] = i;
         drive(which, 1'b1, r, i);
         @(posedge clock);
         #1;
      end
      if (len == which) begin
         for (int k = 0; k < which; k++) begin
            x.cyc = t0 + 32'(which) + 1 + 32'(k);
            x.r   = er[k];
            x.i   = ei[k];
            if (which == 4) q4.push_back(x);
            else q64.push_back(x);
         end
      end
   endtask

   task automatic check_out(input int which, input exp_t x, input logic [15:0] r,
                            input logic [15:0] i);
      n_checks++;
      if (cyc != x.cyc) begin
         n_fail++;
         $display("FAIL out_time n=%0d: element seen at cycle %0d, required cycle %0d",
                  which, cyc, x.cyc);
      end
      n_checks++;
      if (r !== x.r || i !== x.i) begin
         n_fail++;
         $display("FAIL out_data n=%0d cyc=%0d: got r=%h i=%h, required r=%h i=%h",
                  which, cyc, r, i, x.r, x.i);
      end
   endtask

   task automatic monitor();
      exp_t x;
      forever begin
         @(negedge clock);
         if (bus64.odata_en === 1'b1) begin
            if (q64.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_out n=64: odata_en=1 at cycle %0d, required 0", cyc);
            end else begin
               x = q64.pop_front();
               check_out(64, x, bus64.odata_r, bus64.odata_i);
               seen64++;
            end
         end
         if (bus4.odata_en === 1'b1) begin
            if (q4.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_out n=4: odata_en=1 at cycle %0d, required 0", cyc);
            end else begin
               x = q4.pop_front();
               check_out(4, x, bus4.odata_r, bus4.odata_i);
            end
         end
      end
   endtask

   task automatic check_idle(input string name, input logic en, input logic [15:0] r,
                             input logic [15:0] i);
      n_checks++;
      if (en !== 1'b0 || r !== 16'h0 || i !== 16'h0) begin
         n_fail++;
         $display("FAIL %s: got en=%b r=%h i=%h, required en=0 r=0000 i=0000",
                  name, en, r, i);
      end
   endtask

   task automatic main_seq();
      int  base;
      bit  hit;
      int  len;
      reset = 1'b1;
      drive(64, 1'b0, 16'h0, 16'h0);
      drive(4, 1'b0, 16'h0, 16'h0);
      repeat (3) @(posedge clock);
      #1;
      check_idle("reset_state_64", bus64.odata_en, bus64.odata_r, bus64.odata_i);
      check_idle("reset_state_4", bus4.odata_en, bus4.odata_r, bus4.odata_i);
      reset = 1'b0;

      // Single frame straight out of reset, then back-to-back triple.
      send(64, 64, 1, 0);
      idle(64, 80);
      send(64, 64, 1, 0);
      send(64, 64, 1, 100);
      send(64, 64, 1, 200);
      idle(64, 2);

      // Full frame, gap, partial frame (discarded), full frame.
      send(64, 64, 0, 0);
      idle(64, 10);
      send(64, 20, 0, 0);
      idle(64, 3);
      send(64, 64, 0, 0);
      idle(64, 150);

      // Reset while output sample 30 is on the port.
      base = seen64;
      send(64, 64, 1, 300);
      idle(64, 1);
      hit = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (seen64 >= base + 30) begin
            hit = 1'b1;
            break;
         end
         @(posedge clock);
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL reach_sample30: saw %0d samples, required 30", seen64 - base);
      end
      #1;
      reset = 1'b1;
      #1;
      check_idle("reset_mid_read", bus64.odata_en, bus64.odata_r, bus64.odata_i);
      q64.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      send(64, 64, 1, 500);
      idle(64, 2);

      // Random soak: full and partial frames with short or zero gaps.
      for (int k = 0; k < 10; k++) begin
         if ($urandom_range(0, 2) != 0) begin
            send(64, 64, 0, 0);
            idle(64, $urandom_range(0, 4));
         end else begin
            len = $urandom_range(1, 63);
            send(64, len, 0, 0);
            idle(64, $urandom_range(1, 4));
         end
      end

      // N=4: input values 0,2,1,3 come out as 0,1,2,3.
      idle(64, 1);
      send(4, 4, 1, 0);
      idle(4, 8);
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 3) != 0) begin
            send(4, 4, 0, 0);
            idle(4, $urandom_range(0, 2));
         end else begin
            send(4, $urandom_range(1, 3), 0, 0);
            idle(4, $urandom_range(1, 2));
         end
      end
      idle(4, 1);

      for (int k = 0; k < 400; k++) begin
         if (q64.size() == 0 && q4.size() == 0) break;
         @(posedge clock);
      end
      repeat (4) @(posedge clock);
      n_checks++;
      if (q64.size() != 0 || q4.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d outputs still pending, required 0/0",
                  q64.size(), q4.size());
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      seen64   = 0;
      fork
         monitor();
         main_seq();
      join_any
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
